// File: rtl/event_encoder8.sv
// Sequential 8-to-3 event encoder: latches one-hot event pulses into a pending
// bitmap and hands out their indices one at a time over a valid/ready handshake.
module event_encoder8 #(
    parameter int unsigned N_IN    = 8,
    parameter int unsigned IDX_W   = 3,
    parameter int unsigned RR_MODE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [N_IN-1:0]  in,
    output logic [IDX_W-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N_IN-1:0]  pending,
    output logic             overflow
);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  ptr;

    logic              xfer;
    logic [N_IN-1:0]   out_onehot;
    logic [N_IN-1:0]   served;
    logic [N_IN-1:0]   cand;
    logic [N_IN-1:0]   upper_mask;
    logic [N_IN-1:0]   cand_upper;
    logic [N_IN-1:0]   pending_next;
    logic              cand_any;
    logic              ovf_hit;
    logic [IDX_W-1:0]  sel_idx;

    // Index of the lowest set bit; zero when the vector is empty.
    function automatic logic [IDX_W-1:0] lowest_set(input logic [N_IN-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = N_IN - 1; i >= 0; i--) begin
            if (v[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    // Handshake, service mask and next pending bitmap.
    always_comb begin
        out_onehot      = '0;
        out_onehot[out] = 1'b1;
        xfer            = out_valid && out_ready;
        served          = xfer ? out_onehot : '0;
        pending_next    = (pending & ~served) | in;
        ovf_hit         = |(in & pending & ~served);
    end

    // The presented index is never a candidate for its own replacement.
    always_comb begin
        cand       = (state == PRESENT) ? (pending & ~out_onehot) : pending;
        cand_any   = |cand;
        upper_mask = '0;
        for (int i = 0; i < N_IN; i++) begin
            upper_mask[i] = (IDX_W'(i) >= ptr);
        end
        cand_upper = cand & upper_mask;
        if (RR_MODE == 0) begin
            sel_idx = lowest_set(cand);
        end else if (|cand_upper) begin
            sel_idx = lowest_set(cand_upper);
        end else begin
            sel_idx = lowest_set(cand);
        end
    end

    // State, pending bitmap, sticky overflow and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state     <= IDLE;
            pending   <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
            ptr       <= '0;
        end else begin
            pending <= pending_next;
            if (ovf_hit) overflow <= 1'b1;
            // Pointer wraps naturally at the index width.
            if (xfer) ptr <= out + IDX_W'(1);
            case (state)
                IDLE: begin
                    if (cand_any) begin
                        out       <= sel_idx;
                        out_valid <= 1'b1;
                        state     <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (xfer) begin
                        if (cand_any) begin
                            out <= sel_idx;
                        end else begin
                            out_valid <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_event_encoder8.sv
// Scoreboard bench for event_encoder8: fixed-priority and round-robin instances
// share stimulus and are checked against a cycle-level behavioural model.
module tb_event_encoder8;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear;
    logic       out_ready;
    logic [7:0] in;

    logic [2:0] out_fp, out_rr;
    logic       v_fp, v_rr;
    logic [7:0] p_fp, p_rr;
    logic       o_fp, o_rr;

    always #5 clk = ~clk;

    event_encoder8 #(.N_IN(8), .IDX_W(3), .RR_MODE(0)) u_fp (
        .clk(clk), .rst(rst), .clear(clear), .in(in), .out(out_fp),
        .out_valid(v_fp), .out_ready(out_ready), .pending(p_fp), .overflow(o_fp)
    );

    event_encoder8 #(.N_IN(8), .IDX_W(3), .RR_MODE(1)) u_rr (
        .clk(clk), .rst(rst), .clear(clear), .in(in), .out(out_rr),
        .out_valid(v_rr), .out_ready(out_ready), .pending(p_rr), .overflow(o_rr)
    );

    // Reference state per instance: 0 = fixed priority, 1 = round-robin.
    logic [7:0] m_pend [2];
    logic       m_valid[2];
    int         m_idx  [2];
    logic       m_ovf  [2];
    int         m_ptr  [2];

    int q_fp[$];
    int q_rr[$];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // First pending line scanning upward from base, wrapping; -1 when none.
    function automatic int pick(input logic [7:0] c, input int base);
        for (int k = 0; k < 8; k++) begin
            int j;
            j = (base + k) % 8;
            if (c[j]) return j;
        end
        return -1;
    endfunction

    task automatic model_reset(input int m);
        m_pend[m]  = 8'h00;
        m_valid[m] = 1'b0;
        m_idx[m]   = 0;
        m_ovf[m]   = 1'b0;
        m_ptr[m]   = 0;
    endtask

    task automatic model_step(input int m, input logic [7:0] ev, input logic rdy, input logic flush);
        logic       x;
        logic [7:0] oh, srv, cnd;
        int         s;
        if (flush) begin
            model_reset(m);
        end else begin
            x   = m_valid[m] && rdy;
            oh  = 8'(1) << m_idx[m];
            srv = x ? oh : 8'h00;
            cnd = m_valid[m] ? (m_pend[m] & ~oh) : m_pend[m];
            s   = pick(cnd, (m == 1) ? m_ptr[m] : 0);
            if ((ev & m_pend[m] & ~srv) != 8'h00) m_ovf[m] = 1'b1;
            if (x) begin
                if (m == 0) q_fp.push_back(m_idx[m]);
                else        q_rr.push_back(m_idx[m]);
                m_ptr[m] = (m_idx[m] + 1) % 8;
            end
            if (!m_valid[m] || x) begin
                if (s >= 0) begin
                    m_valid[m] = 1'b1;
                    m_idx[m]   = s;
                end else begin
                    m_valid[m] = 1'b0;
                end
            end
            m_pend[m] = (m_pend[m] & ~srv) | ev;
        end
    endtask

    task automatic check_state();
        chk("fp pending",   int'(p_fp), int'(m_pend[0]));
        chk("fp overflow",  int'(o_fp), int'(m_ovf[0]));
        chk("fp out_valid", int'(v_fp), int'(m_valid[0]));
        if (m_valid[0]) chk("fp out held", int'(out_fp), m_idx[0]);
        chk("rr pending",   int'(p_rr), int'(m_pend[1]));
        chk("rr overflow",  int'(o_rr), int'(m_ovf[1]));
        chk("rr out_valid", int'(v_rr), int'(m_valid[1]));
        if (m_valid[1]) chk("rr out held", int'(out_rr), m_idx[1]);
    endtask

    // One clock: check registered state, then drive this cycle's inputs.
    task automatic cyc(input logic [7:0] ev, input logic rdy, input logic clr, input logic r);
        @(posedge clk);
        #1;
        check_state();
        in        = ev;
        out_ready = rdy;
        clear     = clr;
        rst       = r;
        model_step(0, ev, rdy, clr || r);
        model_step(1, ev, rdy, clr || r);
    endtask

    // Transfer monitor: pops the expected index on every accepted output.
    always @(negedge clk) begin
        if (!rst && !clear && out_ready) begin
            if (v_fp === 1'b1) begin
                if (q_fp.size() == 0) chk("fp unexpected transfer", int'(out_fp), -1);
                else                  chk("fp transfer index", int'(out_fp), q_fp.pop_front());
            end
            if (v_rr === 1'b1) begin
                if (q_rr.size() == 0) chk("rr unexpected transfer", int'(out_rr), -1);
                else                  chk("rr transfer index", int'(out_rr), q_rr.pop_front());
            end
        end
    end

    initial begin
        logic [7:0] ev;
        rst = 1'b1; clear = 1'b0; in = 8'h00; out_ready = 1'b0;
        model_reset(0);
        model_reset(1);

        // Reset and idle
        cyc(8'h00, 1'b0, 1'b0, 1'b1);
        cyc(8'h00, 1'b0, 1'b0, 1'b1);
        cyc(8'h00, 1'b0, 1'b0, 1'b0);
        chk("fp out after reset", int'(out_fp), 0);
        chk("rr out after reset", int'(out_rr), 0);

        // Single event on line 5
        cyc(8'h20, 1'b1, 1'b0, 1'b0);
        repeat (5) cyc(8'h00, 1'b1, 1'b0, 1'b0);

        // Three events under back-pressure
        cyc(8'h91, 1'b0, 1'b0, 1'b0);
        repeat (4) cyc(8'h00, 1'b0, 1'b0, 1'b0);
        repeat (5) cyc(8'h00, 1'b1, 1'b0, 1'b0);

        // Re-trigger of line 0 while line 1 is presented
        cyc(8'h00, 1'b0, 1'b0, 1'b1);
        cyc(8'h03, 1'b1, 1'b0, 1'b0);
        cyc(8'h00, 1'b1, 1'b0, 1'b0);
        cyc(8'h00, 1'b1, 1'b0, 1'b0);
        cyc(8'h01, 1'b0, 1'b0, 1'b0);
        repeat (5) cyc(8'h00, 1'b1, 1'b0, 1'b0);

        // Pointer wrap from line 7 back to line 0
        cyc(8'h00, 1'b0, 1'b0, 1'b1);
        cyc(8'h81, 1'b1, 1'b0, 1'b0);
        repeat (4) cyc(8'h00, 1'b1, 1'b0, 1'b0);
        cyc(8'h01, 1'b1, 1'b0, 1'b0);
        repeat (4) cyc(8'h00, 1'b1, 1'b0, 1'b0);

        // Overflow, then a coincident re-trigger on the transfer cycle
        cyc(8'h00, 1'b0, 1'b0, 1'b1);
        cyc(8'h04, 1'b0, 1'b0, 1'b0);
        cyc(8'h04, 1'b0, 1'b0, 1'b0);
        repeat (3) cyc(8'h00, 1'b0, 1'b0, 1'b0);
        cyc(8'h04, 1'b1, 1'b0, 1'b0);
        repeat (4) cyc(8'h00, 1'b1, 1'b0, 1'b0);

        // Coincident re-trigger alone must not raise overflow
        cyc(8'h00, 1'b0, 1'b0, 1'b1);
        cyc(8'h04, 1'b0, 1'b0, 1'b0);
        repeat (2) cyc(8'h00, 1'b0, 1'b0, 1'b0);
        cyc(8'h04, 1'b1, 1'b0, 1'b0);
        repeat (4) cyc(8'h00, 1'b1, 1'b0, 1'b0);

        // Flush mid-operation discards the coincident event
        cyc(8'h00, 1'b0, 1'b0, 1'b1);
        cyc(8'h0F, 1'b0, 1'b0, 1'b0);
        repeat (3) cyc(8'h00, 1'b0, 1'b0, 1'b0);
        cyc(8'h10, 1'b0, 1'b1, 1'b0);
        repeat (3) cyc(8'h00, 1'b1, 1'b0, 1'b0);

        // Randomized traffic with occasional flush and reset
        repeat (3000) begin
            if ($urandom % 3 == 0)      ev = 8'($urandom);
            else if ($urandom % 2 == 0) ev = 8'(1 << ($urandom % 8));
            else                        ev = 8'h00;
            cyc(ev, ($urandom % 4) != 0, ($urandom % 97) == 0, ($urandom % 211) == 0);
        end

        repeat (20) cyc(8'h00, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        chk("fp scoreboard drained", q_fp.size(), 0);
        chk("rr scoreboard drained", q_rr.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/event_encoder8.md
Name: event_encoder8

Overview:
- Sequential 8-to-3 encoder: the inverse direction of the team's 3-to-8 one-hot decoder.
- Captures single-cycle event pulses on up to 8 lines into a pending register.
- Emits the 3-bit index of each pending event, one at a time, over a valid/ready handshake.
- Sits between one-hot event sources (interrupt lines, per-channel done flags) and a consumer that wants encoded indices.

Parameters:
- N_IN, 8, number of event lines; fixed at 8 for this revision.
- IDX_W, 3, index width; must equal clog2(N_IN).
- RR_MODE, 0, selection policy: 0 = fixed priority (lowest index first), 1 = round-robin.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- clear  input  1  synchronous flush of pending state
- in  input  8  event pulses; bit i high for one cycle = one event on line i
- out  output  3  encoded index of the presented event
- out_valid  output  1  out holds a pending event index
- out_ready  input  1  consumer accepts out this cycle
- pending  output  8  registered pending bitmap
- overflow  output  1  sticky flag: an event was merged into an already-pending bit

Behaviour:
- Reset (rst=1 at a clk edge) values: pending=0, out=0, out_valid=0, overflow=0, RR pointer=0, FSM=IDLE.
- rst has priority over clear.
- clear=1 has the same effect as reset. in on that cycle is discarded.
- Handshake: transfer occurs when out_valid && out_ready.
  - While out_valid=1 and no transfer, out holds stable.
  - out_ready while out_valid=0 is ignored.
- Pending update each cycle: pending_next = (pending & ~served) | in.
  - served = onehot(out) on a transfer cycle, else 0.
- Simultaneous served bit and in bit for the same line: the bit stays set (new event). This does not set overflow.
- Overflow: set when in[i]=1, pending[i]=1, and line i is not served that cycle. Remains 1 until rst or clear.
- Candidate set: cand = pending & ~onehot(out) when in PRESENT, else cand = pending. Uses registered pending only; in of the current cycle is never a candidate.
- Selection:
  - RR_MODE=0: lowest set index of cand.
  - RR_MODE=1: first set index of cand at or above the pointer, wrapping 7->0.
  - The pointer updates to (served index + 1) mod 8 on each transfer.
- FSM states:
  - IDLE: out_valid=0. If cand != 0, load out with the selected index, set out_valid=1, go to PRESENT.
  - PRESENT: out_valid=1, out held.
    - On transfer with cand != 0: load the next selected index; out_valid stays 1 (back-to-back, no bubble).
    - On transfer with cand == 0: out_valid=0, go to IDLE.
    - No transfer: stay.
- Latency:
  - An event at in in cycle t appears in pending at t+1.
  - In IDLE, out_valid rises at t+2.
  - Sustained throughput: one index per cycle while out_ready=1 and events remain.
- An event presented on out stays set in pending until its transfer.
- The idle pending bitmap is 0x00; all eight lines pending is 0xFF; no other capacity limit.

Test Plan:
- Reset and idle: rst=1 for 2 cycles, then in=0x00 -> pending=0x00, out_valid=0, out=0, overflow=0.
- Single event: in=0x20 for one cycle, out_ready=1 -> pending=0x20 one cycle later; out_valid=1 with out=5 two cycles after the pulse; out_valid drops after one transfer; pending returns to 0x00.
- Fixed priority, back-pressure: RR_MODE=0, in=0x91 once, out_ready=0 for 3 cycles then 1 -> out=0 held for 3 cycles, then out=0,4,7 on consecutive cycles, then out_valid=0.
- Round-robin: RR_MODE=1, in=0x03 and serve index 0; in=0x01 again while index 1 is presented -> order 0,1,0; pointer wraps correctly from 7 to 0 with in=0x81 -> order 0,7 from reset, then 0 on re-trigger.
- Overflow and coincident events:
  - in=0x04 twice while bit 2 is pending and unserved -> overflow=1, and it stays 1.
  - in=0x04 on the exact transfer cycle of out=2 -> bit 2 re-pends, overflow unchanged, out=2 presented again.
- Flush mid-operation: pending=0x0F with out_valid=1, assert clear with in=0x10 -> next cycle pending=0x00, out_valid=0, overflow=0; the 0x10 event is discarded.
